// File: rtl/regfile.sv
// Two-read, one-write general-purpose register file with a stored carry flag.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports and cf_out.
module regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          cf_we,
  input  logic          cf_in,
  output logic          cf_out
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] regs [NREG];
  logic          cf_q;
  logic          gpr_we;

  // r0 is hardwired to zero, so a write aimed at it never touches the array.
  assign gpr_we = wr_en && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      cf_q <= 1'b0;
    end else begin
      if (gpr_we) begin
        regs[wr_addr] <= wr_data;
      end
      if (cf_we) begin
        cf_q <= cf_in;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    cf_out   = cf_q;
    if (rs1_addr != '0) begin
      rs1_data = (gpr_we && !reset && (wr_addr == rs1_addr)) ? wr_data : regs[rs1_addr];
    end
    if (rs2_addr != '0) begin
      rs2_data = (gpr_we && !reset && (wr_addr == rs2_addr)) ? wr_data : regs[rs2_addr];
    end
    if (cf_we && !reset) begin
      cf_out = cf_in;
    end
  end
`else
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    cf_out   = cf_q;
    if (rs1_addr != '0) begin
      rs1_data = regs[rs1_addr];
    end
    if (rs2_addr != '0) begin
      rs2_data = regs[rs2_addr];
    end
  end
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared against an array-based reference model; follows REGFILE_BYPASS_EN.
module tb_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr;
  logic [31:0] rs1_data, rs2_data, wr_data;
  logic        wr_en, cf_we, cf_in, cf_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [32];
  logic        model_cf;

  regfile #(.DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cf_we(cf_we), .cf_in(cf_in), .cf_out(cf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Value a read port should show right now, given the current inputs.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYPASS && wr_en && !reset && wr_addr == a) return wr_data;
    return model[a];
  endfunction

  function automatic logic exp_cf();
    if (BYPASS && cf_we && !reset) return cf_in;
    return model_cf;
  endfunction

  // Apply the architectural effect of the current inputs, then advance one edge.
  task automatic cycle();
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_cf = 1'b0;
    end else begin
      if (wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
      if (cf_we) model_cf = cf_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wr_en = 1'b0; cf_we = 1'b0; cf_in = 1'b0;
    wr_addr = 5'd0; wr_data = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      total++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
        bad++;
        $display("FAIL reset_read addr=%0d got rs1=%h rs2=%h want 0", i, rs1_data, rs2_data);
      end
    end
    total++;
    if (cf_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_cf got %b want 0", cf_out);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cycle();
    wr_addr = 5'd0; wr_data = 32'h12345678;
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    total++;
    if (rs1_data !== 32'hDEADBEEF || rs2_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL r5_read got rs1=%h rs2=%h want deadbeef", rs1_data, rs2_data);
    end
    cycle();
    wr_en = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    total++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      bad++;
      $display("FAIL r0_write_discard got rs1=%h rs2=%h want 0", rs1_data, rs2_data);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
    cycle();
    wr_data = 32'hA5A5A5A5; rs1_addr = 5'd7; rs2_addr = 5'd5;
    #1;
    want = BYPASS ? 32'hA5A5A5A5 : 32'h00000001;
    total++;
    if (rs1_data !== want) begin
      bad++;
      $display("FAIL same_cycle_r7 got %h want %h", rs1_data, want);
    end
    total++;
    if (rs2_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL same_cycle_other_port got %h want deadbeef", rs2_data);
    end
    cycle();
    wr_en = 1'b0;
    #1;
    total++;
    if (rs1_data !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL next_cycle_r7 got %h want a5a5a5a5", rs1_data);
    end
  endtask

  task automatic test_carry();
    cf_we = 1'b1; cf_in = 1'b1;
    #1;
    total++;
    if (cf_out !== (BYPASS ? 1'b1 : 1'b0)) begin
      bad++;
      $display("FAIL cf_same_cycle got %b want %b", cf_out, BYPASS);
    end
    cycle();
    cf_we = 1'b0; cf_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (cf_out !== 1'b1) begin
        bad++;
        $display("FAIL cf_hold cycle=%0d got %b want 1", i, cf_out);
      end
      cycle();
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFFFFFF;
    cf_we = 1'b1; cf_in = 1'b1;
    cycle();
    idle_inputs();
    rs1_addr = 5'd3; rs2_addr = 5'd7;
    #1;
    total++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || cf_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_priority got r3=%h r7=%h cf=%b want 0 0 0", rs1_data, rs2_data, cf_out);
    end
    // write right after reset deassertion must land
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0BADF00D;
    cycle();
    wr_en = 1'b0; rs1_addr = 5'd9;
    #1;
    total++;
    if (rs1_data !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL write_after_reset got %h want 0badf00d", rs1_data);
    end
  endtask

  task automatic test_pairs();
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
      cycle();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      total++;
      if (rs1_data !== 32'(i) || rs2_data !== 32'(31 - i)) begin
        bad++;
        $display("FAIL pair i=%0d got rs1=%h rs2=%h want %h %h", i, rs1_data, rs2_data, 32'(i), 32'(31 - i));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    logic        ec;
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(24) == 0);
      wr_en    = ($urandom_range(3) != 0);
      wr_addr  = 5'($urandom_range(31));
      wr_data  = $urandom();
      cf_we    = ($urandom_range(2) == 0);
      cf_in    = 1'($urandom_range(1));
      rs1_addr = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom_range(31));
      rs2_addr = ($urandom_range(4) == 0) ? rs1_addr : 5'($urandom_range(31));
      #1;
      e1 = exp_read(rs1_addr);
      e2 = exp_read(rs2_addr);
      ec = exp_cf();
      total++;
      if (rs1_data !== e1 || rs2_data !== e2 || cf_out !== ec) begin
        bad++;
        $display("FAIL random n=%0d a1=%0d a2=%0d got %h %h %b want %h %h %b",
                 n, rs1_addr, rs2_addr, rs1_data, rs2_data, cf_out, e1, e2, ec);
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_cf = 1'b0;
    #2;
    test_reset();
    test_write_read();
    test_same_cycle();
    test_carry();
    test_reset_priority();
    test_pairs();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DW, default 32: data width of every register, read port and write port.
REQ-002 Parameter AW, default 5: address width; register count is 2**AW (32).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 rs1_addr  input  AW  read port 1 address.
REQ-006 rs2_addr  input  AW  read port 2 address.
REQ-007 rs1_data  output  DW  read port 1 data; drives ALU operand A.
REQ-008 rs2_data  output  DW  read port 2 data; drives ALU operand B.
REQ-009 wr_en  input  1  write enable for the GPR write port.
REQ-010 wr_addr  input  AW  write address.
REQ-011 wr_data  input  DW  write data; sourced from ALU res.
REQ-012 cf_we  input  1  carry-flag write enable.
REQ-013 cf_in  input  1  carry-flag next value; sourced from ALU cout.
REQ-014 cf_out  output  1  stored carry flag; drives ALU cin.

Function
REQ-015 Reads SHALL be combinational: rs1_data/rs2_data follow address changes in the same cycle, zero-cycle latency.
REQ-016 Register 0 SHALL read as all-zeros at all times; writes addressed to 0 SHALL be discarded.
REQ-017 When wr_en=1 and reset=0, wr_data SHALL be stored in register wr_addr on the rising edge; visible on read ports from the next cycle.
REQ-018 When wr_en=0, no GPR SHALL change.
REQ-019 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-020 When cf_we=1 and reset=0, cf_in SHALL be stored on the rising edge; cf_out SHALL reflect it from the next cycle.
REQ-021 When cf_we=0, cf_out SHALL hold its value indefinitely.
REQ-022 GPR write and carry-flag write in the same cycle SHALL both take effect; they are independent.
REQ-023 Address values SHALL be used as unsigned indices; no out-of-range case exists (all 2**AW addresses valid).
REQ-024 The block SHALL have no stall, no handshake and no internal state beyond the register array and carry flag.

Reset
REQ-025 On a rising edge with reset=1, all registers and the carry flag SHALL be cleared to 0; from the next cycle rs1_data=rs2_data=0 for every address and cf_out=0.
REQ-026 reset SHALL take precedence over wr_en and cf_we in the same cycle; the write is lost.
REQ-027 Before the first reset edge, register contents are undefined; the bench SHALL not check reads before reset.
REQ-028 A reset pulse of one cycle between writes SHALL clear all earlier writes; writes in the cycle after reset deassertion SHALL be accepted normally.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 With REGFILE_BYPASS_EN defined: when wr_en=1, reset=0, wr_addr!=0 and wr_addr equals a read address, that port SHALL return wr_data in the same cycle (independently per port).
REQ-031 With REGFILE_BYPASS_EN defined: cf_out SHALL return cf_in in the same cycle when cf_we=1 and reset=0.
REQ-032 Without REGFILE_BYPASS_EN: same-cycle reads of the address being written SHALL return the old stored value; the new value appears next cycle.

Verification
REQ-033 Reset then read all 32 addresses on both ports -> every read 0x00000000, cf_out=0.
REQ-034 Write 0xDEADBEEF to r5, next cycle rs1_addr=5, rs2_addr=5 -> both ports 0xDEADBEEF; write 0x12345678 to r0 -> r0 reads 0.
REQ-035 r7 holds 0x1; same cycle write 0xA5A5A5A5 to r7 with rs1_addr=7 -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x00000001 without; next cycle 0xA5A5A5A5 in both builds.
REQ-036 cf_we=1, cf_in=1 -> cf_out=1 next cycle; cf_we=0, cf_in=0 for 5 cycles -> cf_out stays 1.
REQ-037 reset=1 with wr_en=1, wr_addr=3, wr_data=0xFFFFFFFF and cf_we=1, cf_in=1 -> next cycle r3 reads 0, cf_out=0.
REQ-038 Write r1..r31 with value equal to index, read all pairs (rs1_addr=i, rs2_addr=31-i) -> rs1_data=i, rs2_data=31-i (r0 pair reads 0).
